// File: rtl/mano_ac_pkg.sv
// Shared encodings for the Mano accumulator unit: command opcodes and FSM state values.
package mano_ac_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_LDA = 4'd3;
  localparam logic [3:0] OP_CMA = 4'd4;
  localparam logic [3:0] OP_CLA = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_CLE = 4'd7;
  localparam logic [3:0] OP_CME = 4'd8;
  localparam logic [3:0] OP_CIR = 4'd9;
  localparam logic [3:0] OP_CIL = 4'd10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ROT  = 1'b1;

endpackage

// File: rtl/mano_ac_unit.sv
// AC register and E flip-flop with a valid/ready command port, a done pulse,
// and a multi-cycle rotate through E that runs for a programmable step count.
module mano_ac_unit
  import mano_ac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [3:0]       op_code,
  input  logic [CNT_W-1:0] rot_cnt,
  input  logic [WIDTH-1:0] dr,
  output logic             op_ready,
  output logic             done,
  output logic [WIDTH-1:0] ac,
  output logic             e,
  output logic             zero,
  output logic             neg
);

  localparam logic [WIDTH-1:0] AC_ONE  = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] ac_q, ac_d;
  logic             e_q, e_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_left_q, dir_left_d;
  logic             done_q, done_d;

  logic             accept;
  logic             rot_left;
  logic [CNT_W-1:0] n_steps;
  logic [WIDTH:0]   sum;

  // One step of the {ac,e} ring; result packed as {new_ac, new_e}.
  function automatic logic [WIDTH:0] rot_step(input logic [WIDTH-1:0] a,
                                              input logic             ev,
                                              input logic             left);
    if (left) return {a[WIDTH-2:0], ev, a[WIDTH-1]};
    else      return {ev, a[WIDTH-1:1], a[0]};
  endfunction

  assign op_ready = (state_q == ST_IDLE);
  assign accept   = op_valid && op_ready;
  assign rot_left = (op_code == OP_CIL);
  assign n_steps  = (rot_cnt == '0) ? CNT_ONE : rot_cnt;
  assign sum      = {1'b0, ac_q} + {1'b0, dr};

  // NOTE: every next-state signal takes its held value first, so no path leaves one unassigned (no latch).
  always_comb begin
    ac_d       = ac_q;
    e_d        = e_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          done_d = 1'b1;
          case (op_code)
            OP_AND: ac_d = ac_q & dr;
            OP_ADD: {e_d, ac_d} = sum;
            OP_LDA: ac_d = dr;
            OP_CMA: ac_d = ~ac_q;
            OP_CLA: ac_d = '0;
            OP_INC: ac_d = ac_q + AC_ONE;
            OP_CLE: e_d = 1'b0;
            OP_CME: e_d = ~e_q;
            OP_CIR, OP_CIL: begin
              // First step happens on the accept edge; the counter holds the steps still owed.
              dir_left_d  = rot_left;
              {ac_d, e_d} = rot_step(ac_q, e_q, rot_left);
              cnt_d       = n_steps - CNT_ONE;
              if (n_steps != CNT_ONE) begin
                state_d = ST_ROT;
                done_d  = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      ST_ROT: begin
        {ac_d, e_d} = rot_step(ac_q, e_q, dir_left_q);
        cnt_d       = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ac_q       <= '0;
      e_q        <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ac_q       <= ac_d;
      e_q        <= e_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_left_q <= dir_left_d;
      done_q     <= done_d;
    end
  end

  assign done = done_q;
  assign ac   = ac_q;
  assign e    = e_q;
  assign zero = (ac_q == '0);
  assign neg  = ac_q[WIDTH-1];

endmodule

// File: tb/tb_mano_ac_unit.sv
// Directed bench for mano_ac_unit (WIDTH=8, CNT_W=4); expected values are hand-computed.
module tb_mano_ac_unit;
  import mano_ac_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [3:0] op_code;
  logic [3:0] rot_cnt;
  logic [7:0] dr;
  logic       op_ready;
  logic       done;
  logic [7:0] ac;
  logic       e;
  logic       zero;
  logic       neg;

  int tests_run    = 0;
  int tests_failed = 0;

  // Observed bundle {ac, e, op_ready, done}.
  logic [10:0] obs;
  assign obs = {ac, e, op_ready, done};

  mano_ac_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .rot_cnt  (rot_cnt),
    .dr       (dr),
    .op_ready (op_ready),
    .done     (done),
    .ac       (ac),
    .e        (e),
    .zero     (zero),
    .neg      (neg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; op_code = OP_NOP; rot_cnt = 4'd0; dr = 8'h00;
    step(); step();
    tests_run++;
    if (obs !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL reset_state: got %h, expected %h", obs, {8'h00, 1'b0, 1'b1, 1'b0});
    end
    tests_run++;
    if ({zero, neg} !== 2'b10) begin
      tests_failed++; $display("FAIL reset_flags: got zero/neg %b, expected 10", {zero, neg});
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    op_valid = 1'b1; op_code = OP_LDA; dr = 8'hF0;
    step();
    tests_run++;
    if (obs !== {8'hF0, 1'b0, 1'b1, 1'b1}) begin
      tests_failed++; $display("FAIL b2b_lda: got %h, expected %h", obs, {8'hF0, 1'b0, 1'b1, 1'b1});
    end
    op_code = OP_AND; dr = 8'h3C;
    step();
    tests_run++;
    if (obs !== {8'h30, 1'b0, 1'b1, 1'b1}) begin
      tests_failed++; $display("FAIL b2b_and: got %h, expected %h", obs, {8'h30, 1'b0, 1'b1, 1'b1});
    end
    op_code = OP_ADD; dr = 8'hE0;
    step();
    tests_run++;
    if (obs !== {8'h10, 1'b1, 1'b1, 1'b1}) begin
      tests_failed++; $display("FAIL b2b_add_carry: got %h, expected %h", obs, {8'h10, 1'b1, 1'b1, 1'b1});
    end
    op_valid = 1'b0; dr = 8'hFF;
    step();
    tests_run++;
    if (obs !== {8'h10, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL b2b_idle: got %h, expected %h", obs, {8'h10, 1'b1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_cma_inc();
    op_valid = 1'b1; op_code = OP_CMA;
    step();
    tests_run++;
    if ({obs, neg, zero} !== {8'hEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL cma: got %h, expected %h", {obs, neg, zero}, {8'hEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    end
    op_code = OP_LDA; dr = 8'hFF;
    step();
    op_code = OP_INC;
    step();
    tests_run++;
    if ({obs, zero, neg} !== {8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL inc_wrap: got %h, expected %h", {obs, zero, neg}, {8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    end
    op_valid = 1'b0;
    step();
  endtask

  task automatic test_rotate();
    int busy;
    op_valid = 1'b1; op_code = OP_CLE;
    step();
    tests_run++;
    if (e !== 1'b0) begin
      tests_failed++; $display("FAIL cle: got e=%b, expected 0", e);
    end
    op_code = OP_LDA; dr = 8'h81;
    step();
    op_code = OP_CIL; rot_cnt = 4'd3;
    step();
    op_valid = 1'b0;
    tests_run++;
    if (obs !== {8'h02, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL cil3_s1: got %h, expected %h", obs, {8'h02, 1'b1, 1'b0, 1'b0});
    end
    step();
    tests_run++;
    if (obs !== {8'h05, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL cil3_s2: got %h, expected %h", obs, {8'h05, 1'b0, 1'b0, 1'b0});
    end
    step();
    tests_run++;
    if (obs !== {8'h0A, 1'b0, 1'b1, 1'b1}) begin
      tests_failed++; $display("FAIL cil3_s3: got %h, expected %h", obs, {8'h0A, 1'b0, 1'b1, 1'b1});
    end
    step();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++; $display("FAIL cil3_done_once: got done=%b, expected 0", done);
    end
    // Nine steps through the 9-bit ring must come back to the start.
    op_valid = 1'b1; op_code = OP_CIR; rot_cnt = 4'd9;
    step();
    op_valid = 1'b0;
    tests_run++;
    if (obs !== {8'h05, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL cir9_s1: got %h, expected %h", obs, {8'h05, 1'b0, 1'b0, 1'b0});
    end
    busy = (op_ready === 1'b0) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (op_ready === 1'b0) busy++;
    end
    tests_run++;
    if (obs !== {8'h0A, 1'b0, 1'b1, 1'b1}) begin
      tests_failed++; $display("FAIL cir9_restore: got %h, expected %h", obs, {8'h0A, 1'b0, 1'b1, 1'b1});
    end
    tests_run++;
    if (busy != 8) begin
      tests_failed++; $display("FAIL cir9_busy_cycles: got %0d, expected 8", busy);
    end
  endtask

  task automatic test_hold_during_rot();
    logic [8:0] exp_ring [4];
    exp_ring[0] = {8'h02, 1'b1};
    exp_ring[1] = {8'h81, 1'b0};
    exp_ring[2] = {8'h40, 1'b1};
    exp_ring[3] = {8'hA0, 1'b0};
    op_valid = 1'b1; op_code = OP_CIR; rot_cnt = 4'd5; dr = 8'h00;
    step();
    tests_run++;
    if (obs !== {8'h05, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL hold_s1: got %h, expected %h", obs, {8'h05, 1'b0, 1'b0, 1'b0});
    end
    op_code = OP_LDA; dr = 8'h55;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if ({ac, e} !== exp_ring[i]) begin
        tests_failed++; $display("FAIL hold_step%0d: got %h, expected %h", i + 2, {ac, e}, exp_ring[i]);
      end
    end
    tests_run++;
    if ({op_ready, done} !== 2'b11) begin
      tests_failed++; $display("FAIL hold_end_flags: got ready/done %b, expected 11", {op_ready, done});
    end
    step();
    tests_run++;
    if (obs !== {8'h55, 1'b0, 1'b1, 1'b1}) begin
      tests_failed++; $display("FAIL hold_lda_after: got %h, expected %h", obs, {8'h55, 1'b0, 1'b1, 1'b1});
    end
    op_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_abort();
    op_valid = 1'b1; op_code = OP_CIL; rot_cnt = 4'd6;
    step();
    op_valid = 1'b0;
    tests_run++;
    if (obs !== {8'hAA, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL abort_s1: got %h, expected %h", obs, {8'hAA, 1'b0, 1'b0, 1'b0});
    end
    rst = 1'b1;
    step();
    tests_run++;
    if (obs !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL abort_reset: got %h, expected %h", obs, {8'h00, 1'b0, 1'b1, 1'b0});
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (obs !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL abort_no_done: got %h, expected %h", obs, {8'h00, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_reserved_and_count0();
    op_valid = 1'b1; op_code = OP_LDA; dr = 8'h3C;
    step();
    op_code = OP_CME;
    step();
    op_code = 4'hF; dr = 8'h00;
    step();
    tests_run++;
    if (obs !== {8'h3C, 1'b1, 1'b1, 1'b1}) begin
      tests_failed++; $display("FAIL reserved_op: got %h, expected %h", obs, {8'h3C, 1'b1, 1'b1, 1'b1});
    end
    op_code = OP_NOP;
    step();
    tests_run++;
    if (obs !== {8'h3C, 1'b1, 1'b1, 1'b1}) begin
      tests_failed++; $display("FAIL nop: got %h, expected %h", obs, {8'h3C, 1'b1, 1'b1, 1'b1});
    end
    op_code = OP_CIR; rot_cnt = 4'd0;
    step();
    tests_run++;
    if (obs !== {8'h9E, 1'b0, 1'b1, 1'b1}) begin
      tests_failed++; $display("FAIL cir_cnt0: got %h, expected %h", obs, {8'h9E, 1'b0, 1'b1, 1'b1});
    end
    op_valid = 1'b0;
    step();
    tests_run++;
    if (obs !== {8'h9E, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL cir_cnt0_idle: got %h, expected %h", obs, {8'h9E, 1'b0, 1'b1, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_cma_inc();
    test_rotate();
    test_hold_during_rot();
    test_reset_abort();
    test_reserved_and_count0();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
